// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/result bundle between the control unit / register
// bank (master) and the iterative multiply/divide unit (slave).
//   Start   - begin operation (level, sampled only while the unit is idle)
//   Op      - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B    - operands (bank read ports L1, L2)
//   Busy    - operation in progress
//   Done    - one-cycle completion pulse
//   Hi, Lo  - product upper/lower half, or remainder/quotient
//   DivZero - last divide had a zero divisor
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivZero;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, Hi, Lo, DivZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, Hi, Lo, DivZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply (shift-add) and divide
// (restoring), one bit per cycle. The 2*WIDTH result is held in Hi/Lo until
// the next operation completes.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; discards any in-flight operation
//   bus - mult_div_unit_if slave: Start/Op/A/B in, Busy/Done/Hi/Lo/DivZero out
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic               is_div;
  logic               neg_q;     // negate product / quotient in FIX
  logic               neg_r;     // negate remainder in FIX
  logic               dz_pend;   // divide-by-zero result still to be posted
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;

  logic               start_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_keep;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    start_signed = bus.Op[0];
    a_mag = (start_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag = (start_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    // Remainder after a restore is always below the divisor, so only the
    // shifted value needs the extra bit; one more bit exposes the borrow.
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mcand};
    div_keep = ~div_diff[WIDTH+1];

    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_pend     <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
      bus.Hi      <= '0;
      bus.Lo      <= '0;
      bus.DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            is_div <= bus.Op[1];
            cnt    <= '0;
            if (bus.Op[1] && bus.B == '0) begin
              // Raw dividend is parked in acc so A may change after Start.
              dz_pend <= 1'b1;
              acc     <= {{WIDTH{1'b0}}, bus.A};
              state   <= DONE;
            end else begin
              neg_q    <= start_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_r    <= start_signed && bus.Op[1] && bus.A[WIDTH-1];
              mcand    <= bus.Op[1] ? b_mag : a_mag;
              acc      <= {{WIDTH{1'b0}}, (bus.Op[1] ? a_mag : b_mag)};
              bus.Busy <= 1'b1;
              state    <= CALC;
            end
          end
        end

        CALC: begin
          if (is_div)
            acc <= {(div_keep ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_keep};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
          if (cnt == LAST)
            state <= FIX;
        end

        FIX: begin
          if (is_div) begin
            bus.Hi <= r_fix;
            bus.Lo <= q_fix;
          end else begin
            bus.Hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.Lo <= prod_fix[WIDTH-1:0];
          end
          bus.DivZero <= 1'b0;
          bus.Busy    <= 1'b0;
          bus.Done    <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          // A divide-by-zero arrives here one cycle early and posts its
          // result here, so Done follows Start by a single cycle.
          if (dz_pend) begin
            bus.Hi      <= acc[WIDTH-1:0];
            bus.Lo      <= '1;
            bus.DivZero <= 1'b1;
            bus.Done    <= 1'b1;
            dz_pend     <= 1'b0;
          end else begin
            bus.Done <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation at the next rising edge (E0), optionally disturb
  // Start/A/B during CALC, then wait (bounded) for Done and check results.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input logic exp_dz,
                        input int exp_lat, input bit disturb);
    int lat;
    bit busy_bad;
    @(negedge clk);
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    if (bus.Busy !== !exp_dz) busy_bad = 1'b1;
    while (bus.Done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.Done && bus.Busy !== !exp_dz) busy_bad = 1'b1;
      if (disturb && lat == 5) begin
        bus.Start = 1'b1;
        bus.A = 32'h0000_1111;
        bus.B = 32'h0000_2222;
        bus.Op = 2'b10;
      end
      if (disturb && lat == 6) bus.Start = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    check({tag, " busy at done"}, 64'(bus.Busy), 64'd0);
    check({tag, " result"}, {bus.Hi, bus.Lo}, exp_res);
    check({tag, " divzero"}, 64'(bus.DivZero), 64'(exp_dz));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    int lat;
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", {bus.Hi, bus.Lo}, 64'd0);
    check("reset flags", {61'd0, bus.Busy, bus.Done, bus.DivZero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33, 1'b0);
    run_op("mult neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33, 1'b0);
    run_op("mult minint", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33, 1'b0);
    run_op("divu", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 1'b0);
    run_op("div negdvd", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 1'b0);
    run_op("div negdvs", 2'b11, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 33, 1'b0);
    run_op("div overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 33, 1'b0);
    run_op("div by zero", 2'b11, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1, 1, 1'b0);
    run_op("multu after dz", 2'b00, 32'd2, 32'd3, 64'd6, 1'b0, 33, 1'b0);
    run_op("ignore restart", 2'b00, 32'd5, 32'd6, 64'd30, 1'b0, 33, 1'b1);

    // Start held high: back-to-back operations every 35 cycles.
    @(negedge clk);
    bus.Op = 2'b00;
    bus.A = 32'd3;
    bus.B = 32'd4;
    bus.Start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.Done !== 1'b1 && lat < 100);
    check("held first done", 64'(lat), 64'd34);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.Done !== 1'b1 && lat < 100);
    bus.Start = 1'b0;
    check("held period", 64'(lat), 64'd35);
    check("held result", {bus.Hi, bus.Lo}, 64'd12);
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.Op = 2'b10;
    bus.A = 32'd50;
    bus.B = 32'd5;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst result", {bus.Hi, bus.Lo}, 64'd0);
    check("async rst flags", {61'd0, bus.Busy, bus.Done, bus.DivZero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu after rst", 2'b10, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
